// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_hilo_if #(parameter int WL = 32);
  logic start;
  logic [1:0] op;
  logic [WL-1:0] x;
  logic [WL-1:0] y;
  logic mthi;
  logic mtlo;
  logic [WL-1:0] wdata;
  logic busy;
  logic done;
  logic div_by_zero;
  logic [WL-1:0] hi;
  logic [WL-1:0] lo;
  modport master(output start, op, x, y, mthi, mtlo, wdata, input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, x, y, mthi, mtlo, wdata, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; division stays iterative.
module muldiv_hilo #(parameter int WL = 32) (
  input logic clk,
  input logic rst_n,
  muldiv_hilo_if.slave bus
);
  localparam int CW = $clog2(WL);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WL-1:0] b;
  logic [2*WL-1:0] acc;
  logic is_div, neg_q, neg_r;
  logic sx, sy, go, ge;
  logic [WL-1:0] xm, ym, qfix, rfix;
  logic [WL:0] madd, trial, rdiff;
  logic [2*WL-1:0] pfix;
  // Signed ops work on magnitudes; the signs are reapplied in FIX.
  always_comb begin
    sx = ~bus.op[0] & bus.x[WL-1];
    sy = ~bus.op[0] & bus.y[WL-1];
    xm = sx ? -bus.x : bus.x;
    ym = sy ? -bus.y : bus.y;
    go = bus.start & (state == IDLE || state == DONE);
    madd = {1'b0, acc[2*WL-1:WL]} + (acc[0] ? {1'b0, b} : '0);
    trial = {acc[2*WL-1:WL], acc[WL-1]};
    rdiff = trial - {1'b0, b};
    ge = ~rdiff[WL];
    pfix = neg_q ? -acc : acc;
    qfix = neg_q ? -acc[WL-1:0] : acc[WL-1:0];
    rfix = neg_r ? -acc[2*WL-1:WL] : acc[2*WL-1:WL];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      b <= '0;
      acc <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        IDLE, DONE:
          if (go) begin
            cnt <= '0;
            is_div <= bus.op[1];
            neg_q <= sx ^ sy;
            neg_r <= sx;
            if (bus.op[1]) begin
              b <= ym;
              acc <= {{WL{1'b0}}, xm};
              if (bus.y == '0) begin
                state <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.div_by_zero <= 1'b1;
              end else begin
                state <= DIV;
                bus.busy <= 1'b1;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc <= {{WL{1'b0}}, xm} * {{WL{1'b0}}, ym};
              state <= FIX;
`else
              b <= xm;
              acc <= {{WL{1'b0}}, ym};
              state <= MUL;
`endif
              bus.busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
            bus.busy <= 1'b0;
            if (state == IDLE && bus.mthi) bus.hi <= bus.wdata;
            if (state == IDLE && bus.mtlo) bus.lo <= bus.wdata;
          end
        MUL: begin
          acc <= {madd, acc[WL-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WL - 1)) state <= FIX;
        end
        DIV: begin
          acc <= {ge ? rdiff[WL-1:0] : trial[WL-1:0], acc[WL-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WL - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          {bus.hi, bus.lo} <= is_div ? {rfix, qfix} : pfix;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed checks of muldiv_hilo results, latency, HI/LO writes and reset abort.
module tb_muldiv_hilo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int n;
  logic [31:0] h0, l0;
  logic seen;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  muldiv_hilo_if #(.WL(32)) bus ();
  muldiv_hilo #(.WL(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op from #1 after an edge; n counts edges from acceptance until done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] c, output int cyc);
    bus.op = o;
    bus.x = a;
    bus.y = c;
    bus.start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end while (!bus.done && cyc < 100);
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    bus.op = 2'b00;
    bus.x = '0;
    bus.y = '0;
    bus.wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 67'b0) begin fails++; $display("FAIL reset_state: got %h expected 0", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++; if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'b0) begin fails++; $display("FAIL idle_after_reset: got %h expected 0", {bus.busy, bus.done, bus.hi, bus.lo}); end
  endtask

  task automatic test_mul;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    tests++; if (n !== MUL_LAT) begin fails++; $display("FAIL multu_latency: got %0d expected %0d", n, MUL_LAT); end
    tests++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_in_done: got %b expected 0", bus.busy); end
    @(posedge clk);
    #1;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b expected 0", bus.done); end
    do_op(2'b00, 32'd6, 32'd7, n);
    tests++; if (n !== MUL_LAT || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin fails++; $display("FAIL mult_6x7: got n=%0d %h_%h expected n=%0d 00000000_0000002a", n, bus.hi, bus.lo, MUL_LAT); end
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, n);
    tests++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", bus.hi, bus.lo); end
  endtask

  task automatic test_div;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    tests++; if (n !== DIV_LAT) begin fails++; $display("FAIL div_latency: got %0d expected %0d", n, DIV_LAT); end
    tests++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_dividend: got %h_%h expected ffffffff_fffffffd", bus.hi, bus.lo); end
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, n);
    tests++; if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_divisor: got %h_%h expected 00000001_fffffffd", bus.hi, bus.lo); end
    do_op(2'b11, 32'd100, 32'd7, n);
    tests++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin fails++; $display("FAIL divu_100_7: got %h_%h expected 00000002_0000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back;
    do_op(2'b01, 32'h0001_0000, 32'h0001_0000, n);
    tests++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin fails++; $display("FAIL b2b_first: got %h_%h expected 00000001_00000000", bus.hi, bus.lo); end
    do_op(2'b01, 32'd3, 32'd4, n);
    tests++; if (n !== MUL_LAT || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin fails++; $display("FAIL b2b_second: got n=%0d %h_%h expected n=%0d 00000000_0000000c", n, bus.hi, bus.lo, MUL_LAT); end
  endtask

  task automatic test_div_zero;
    h0 = bus.hi;
    l0 = bus.lo;
    do_op(2'b11, 32'd100, 32'd0, n);
    tests++; if (n !== 1 || bus.div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_pulse: got n=%0d dbz=%b expected n=1 dbz=1", n, bus.div_by_zero); end
    tests++; if (bus.hi !== h0 || bus.lo !== l0) begin fails++; $display("FAIL dbz_hilo_kept: got %h_%h expected %h_%h", bus.hi, bus.lo, h0, l0); end
    @(posedge clk);
    #1;
    tests++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_one_cycle: got done=%b dbz=%b expected 0 0", bus.done, bus.div_by_zero); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    tests++; if (n !== DIV_LAT || bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000 || bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL div_overflow: got n=%0d %h_%h dbz=%b expected n=%0d 00000000_80000000 dbz=0", n, bus.hi, bus.lo, bus.div_by_zero, DIV_LAT); end
  endtask

  task automatic test_ignore;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.op = 2'b00;
    bus.x = 32'd5;
    bus.y = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 1;
    repeat (9) begin @(posedge clk); #1; n++; end
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.x = 32'd100;
    bus.y = 32'd100;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.wdata = 32'h1234;
    @(posedge clk);
    #1;
    n++;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    tests++; if (bus.busy !== 1'b1 || bus.hi !== h0 || bus.lo !== l0) begin fails++; $display("FAIL busy_hilo_stable: got busy=%b %h_%h expected busy=1 %h_%h", bus.busy, bus.hi, bus.lo, h0, l0); end
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (n !== MUL_LAT || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin fails++; $display("FAIL ignored_start: got n=%0d %h_%h expected n=%0d 00000000_0000000f", n, bus.hi, bus.lo, MUL_LAT); end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= bus.busy | bus.done; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL start_not_queued: got activity=%b expected 0", seen); end
  endtask

  task automatic test_mt;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.wdata = 32'hA5;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    tests++; if (bus.hi !== 32'hA5 || bus.lo !== 32'hA5) begin fails++; $display("FAIL mthi_mtlo: got %h_%h expected 000000a5_000000a5", bus.hi, bus.lo); end
    bus.mtlo = 1'b1;
    bus.wdata = 32'h5A;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    tests++; if (bus.hi !== 32'hA5 || bus.lo !== 32'h5A) begin fails++; $display("FAIL mtlo_only: got %h_%h expected 000000a5_0000005a", bus.hi, bus.lo); end
    bus.mthi = 1'b1;
    bus.wdata = 32'h77;
    bus.op = 2'b11;
    bus.x = 32'd17;
    bus.y = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    tests++; if (bus.hi !== 32'hA5 || bus.busy !== 1'b1) begin fails++; $display("FAIL start_beats_mthi: got hi=%h busy=%b expected hi=000000a5 busy=1", bus.hi, bus.busy); end
    n = 1;
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (n !== DIV_LAT || bus.hi !== 32'd2 || bus.lo !== 32'd3) begin fails++; $display("FAIL divu_17_5: got n=%0d %h_%h expected n=%0d 00000002_00000003", n, bus.hi, bus.lo, DIV_LAT); end
  endtask

  task automatic test_reset_mid;
    bus.op = 2'b10;
    bus.x = 32'd100;
    bus.y = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 67'b0) begin fails++; $display("FAIL async_reset: got %h expected 0", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= bus.done | bus.busy; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done: got activity=%b expected 0", seen); end
    do_op(2'b11, 32'd9, 32'd4, n);
    tests++; if (n !== DIV_LAT || bus.hi !== 32'd1 || bus.lo !== 32'd2) begin fails++; $display("FAIL divu_after_reset: got n=%0d %h_%h expected n=%0d 00000001_00000002", n, bus.hi, bus.lo, DIV_LAT); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_div_zero();
    test_ignore();
    test_mt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
